// File: rtl/tb_crc_attach.sv
// Transport-block CRC24A attachment stage feeding cb_seg.
// Takes a TB length A, streams A bits through, then appends the 24 parity
// bits MSB first. Writes B = A+24 to the segmenter's size port first.
module tb_crc_attach #(
  parameter int               SIZE_W = 16,
  parameter int               CRC_W  = 24,
  parameter logic [CRC_W-1:0] POLY   = 24'h864CFB
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              size_valid,
  input  logic [SIZE_W-1:0] size_in,
  output logic              size_ready,
  input  logic              data_valid,
  input  logic              data_in,
  output logic              data_ready,
  input  logic              hold,
  output logic              tb_out,
  output logic              wreq_data,
  output logic [SIZE_W-1:0] tb_size_out,
  output logic              wreq_size,
  output logic              busy,
  output logic              size_err
);

  // Largest A whose B = A+CRC_W still fits in SIZE_W bits.
  localparam int                MAX_A_I  = (2**SIZE_W) - 1 - CRC_W;
  localparam logic [SIZE_W-1:0] MAX_A    = MAX_A_I[SIZE_W-1:0];
  localparam logic [SIZE_W-1:0] CRC_LEN  = SIZE_W'(CRC_W);
  localparam logic [SIZE_W-1:0] CRC_LAST = SIZE_W'(CRC_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_SIZE, S_DATA, S_CRC} state_t;

  state_t            state;
  logic [SIZE_W-1:0] a_len;
  logic [SIZE_W-1:0] cnt;
  logic [CRC_W-1:0]  crc;
  logic              size_hs;
  logic              data_hs;
  logic              crc_fb;
  logic [CRC_W-1:0]  crc_step;

  // Handshake flags are decoded straight from the state register; data_ready
  // is additionally gated by hold so back-pressure blocks a handshake in the
  // very cycle hold rises.
  assign size_ready = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign data_ready = (state == S_DATA) && !hold;
  assign size_hs    = size_valid && size_ready;
  assign data_hs    = data_valid && data_ready;

  // One serial CRC step: feedback is the outgoing MSB xor the incoming bit.
  assign crc_fb   = crc[CRC_W-1] ^ data_in;
  assign crc_step = {crc[CRC_W-2:0], 1'b0} ^ (crc_fb ? POLY : '0);

  // Control FSM with registered strobes, bit counter and CRC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      a_len       <= '0;
      cnt         <= '0;
      crc         <= '0;
      tb_out      <= 1'b0;
      wreq_data   <= 1'b0;
      tb_size_out <= '0;
      wreq_size   <= 1'b0;
      size_err    <= 1'b0;
    end else begin
      wreq_data <= 1'b0;
      wreq_size <= 1'b0;
      size_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (size_hs) begin
            if (size_in > MAX_A) begin
              size_err <= 1'b1;
            end else begin
              a_len <= size_in;
              crc   <= '0;
              cnt   <= '0;
              state <= S_SIZE;
            end
          end
        end
        S_SIZE: begin
          if (!hold) begin
            wreq_size   <= 1'b1;
            tb_size_out <= a_len + CRC_LEN;
            state       <= (a_len == '0) ? S_CRC : S_DATA;
          end
        end
        S_DATA: begin
          if (data_hs) begin
            tb_out    <= data_in;
            wreq_data <= 1'b1;
            crc       <= crc_step;
            if (cnt == a_len - 1'b1) begin
              cnt   <= '0;
              state <= S_CRC;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_CRC: begin
          if (!hold) begin
            tb_out    <= crc[CRC_W-1];
            wreq_data <= 1'b1;
            crc       <= {crc[CRC_W-2:0], 1'b0};
            if (cnt == CRC_LAST) begin
              cnt   <= '0;
              state <= S_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tb_crc_attach.sv
// Self-checking bench for tb_crc_attach. Reference frames come from
// polynomial long division of M(x)*x^24 by the CRC24A generator.
module tb_tb_crc_attach;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        size_valid = 1'b0;
  logic [15:0] size_in = '0;
  logic        size_ready;
  logic        data_valid = 1'b0;
  logic        data_in = 1'b0;
  logic        data_ready;
  logic        hold = 1'b0;
  logic        tb_out;
  logic        wreq_data;
  logic [15:0] tb_size_out;
  logic        wreq_size;
  logic        busy;
  logic        size_err;

  tb_crc_attach dut (
    .clk(clk), .reset(reset), .size_valid(size_valid), .size_in(size_in),
    .size_ready(size_ready), .data_valid(data_valid), .data_in(data_in),
    .data_ready(data_ready), .hold(hold), .tb_out(tb_out),
    .wreq_data(wreq_data), .tb_size_out(tb_size_out), .wreq_size(wreq_size),
    .busy(busy), .size_err(size_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic hold_q = 1'b0;
  int err_pulses = 0;
  int hold_viol = 0;

  logic        obs_q[$];
  int          obs_cyc[$];
  logic [15:0] sz_q[$];
  int          sz_cyc[$];
  int          hs_cyc[$];
  logic        exp_q[$];

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    hold_q <= hold;
  end

  // Output monitor: records every strobe with the cycle it became visible.
  always @(negedge clk) begin
    if (wreq_data === 1'b1) begin obs_q.push_back(tb_out); obs_cyc.push_back(cyc); end
    if (wreq_size === 1'b1) begin sz_q.push_back(tb_size_out); sz_cyc.push_back(cyc); end
    if (size_err === 1'b1) err_pulses++;
    if (hold_q && (wreq_data === 1'b1 || wreq_size === 1'b1)) hold_viol++;
  end

  function automatic void clear();
    obs_q.delete(); obs_cyc.delete(); sz_q.delete(); sz_cyc.delete();
    hs_cyc.delete(); exp_q.delete();
  endfunction

  // Appends message followed by remainder of M(x)*x^24 mod G(x) to exp_q.
  function automatic void model(input logic msg[$]);
    logic        w[$];
    logic [24:0] g;
    g = {1'b1, 24'h864CFB};
    w = msg;
    for (int j = 0; j < 24; j++) w.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (w[i]) for (int j = 0; j < 25; j++) w[i+j] = w[i+j] ^ g[24-j];
    foreach (msg[i]) exp_q.push_back(msg[i]);
    for (int j = 0; j < 24; j++) exp_q.push_back(w[msg.size()+j]);
  endfunction

  // -1 on length difference, else number of differing bit positions.
  function automatic int frame_diff();
    int d = 0;
    if (obs_q.size() != exp_q.size()) return -1;
    foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  // Counts handshakes whose output did not appear exactly one cycle later.
  function automatic int latency_err(input int a1, input int off2);
    int e = 0;
    foreach (hs_cyc[i]) begin
      int k = (i < a1) ? i : i + off2;
      if (k >= obs_cyc.size() || obs_cyc[k] != hs_cyc[i]) e++;
    end
    return e;
  endfunction

  function automatic void rand_bits(input int n, output logic b[$]);
    b.delete();
    for (int i = 0; i < n; i++) b.push_back(1'($urandom));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; size_valid = 1'b0; data_valid = 1'b0; hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_size(input int a);
    int n = 0;
    @(negedge clk);
    size_valid = 1'b1; size_in = 16'(a);
    while (!size_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin n_chk++; $display("FAIL size_handshake: timeout waiting size_ready"); end
    @(negedge clk);
    size_valid = 1'b0;
  endtask

  task automatic send_bits(input logic b[$], input int gap_pct, input int hold_at, input int hold_len);
    int i = 0, n = 0, hc = 0;
    while (i < b.size() && n < 2000) begin
      @(negedge clk); #1; n++;
      if (hc > 0) begin hold = 1'b1; hc--; end else hold = 1'b0;
      data_valid = ($urandom_range(99) >= gap_pct);
      data_in    = data_valid ? b[i] : 1'($urandom);
      #1;
      if (hold && data_ready) hold_viol++;
      if (data_valid && data_ready) begin
        hs_cyc.push_back(cyc + 1);
        i++;
        if (i == hold_at) hc = hold_len;
      end
    end
    if (n >= 2000) begin n_chk++; $display("FAIL send_bits: timeout after %0d of %0d bits", i, b.size()); end
    @(negedge clk);
    data_valid = 1'b0; hold = 1'b0;
  endtask

  task automatic wait_frame(input int total, input int hold_after, input int hold_len);
    int n = 0, hc = 0;
    bit done_hold = 1'b0;
    while (obs_q.size() < total && n < 1000) begin
      @(negedge clk); #1; n++;
      if (hc > 0) begin hold = 1'b1; hc--; end else hold = 1'b0;
      if (!done_hold && hold_after >= 0 && obs_q.size() >= hold_after) begin
        hc = hold_len; done_hold = 1'b1;
      end
    end
    hold = 1'b0;
    if (n >= 1000) begin n_chk++; $display("FAIL wait_frame: timeout, got %0d of %0d bits", obs_q.size(), total); end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); #1;
    n_chk++; if (size_ready !== 1'b1) $display("FAIL reset_size_ready: got %b want 1", size_ready); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (data_ready !== 1'b0) $display("FAIL reset_data_ready: got %b want 0", data_ready); else n_pass++;
    n_chk++; if ({wreq_data, wreq_size, size_err, tb_out} !== 4'b0)
      $display("FAIL reset_strobes: got %b want 0000", {wreq_data, wreq_size, size_err, tb_out}); else n_pass++;
    n_chk++; if (tb_size_out !== 16'd0) $display("FAIL reset_size_out: got %0d want 0", tb_size_out); else n_pass++;
  endtask

  task automatic test_zero_len();
    logic e[$];
    clear();
    send_size(0);
    #1;
    n_chk++; if (busy !== 1'b1) $display("FAIL zero_busy_high: got %b want 1", busy); else n_pass++;
    wait_frame(24, -1, 0);
    @(negedge clk); #1;
    model(e);
    n_chk++; if (sz_q.size() != 1 || sz_q[0] !== 16'd24)
      $display("FAIL zero_size: got %0d writes, first %0d, want 1 write of 24", sz_q.size(), sz_q.size() ? sz_q[0] : 0); else n_pass++;
    n_chk++; if (frame_diff() != 0) $display("FAIL zero_frame: diff %0d want 0", frame_diff()); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL zero_busy_low: got %b want 0", busy); else n_pass++;
    n_chk++; if (sz_cyc.size() == 0 || obs_cyc.size() == 0 || sz_cyc[0] >= obs_cyc[0])
      $display("FAIL zero_order: size write not before first data write"); else n_pass++;
  endtask

  task automatic test_one_bit();
    logic b[$];
    logic [23:0] par = '0;
    clear();
    b.push_back(1'b1);
    model(b);
    send_size(1);
    send_bits(b, 0, -1, 0);
    wait_frame(25, -1, 0);
    if (obs_q.size() == 25) for (int j = 0; j < 24; j++) par[23-j] = obs_q[1+j];
    n_chk++; if (sz_q.size() != 1 || sz_q[0] !== 16'd25) $display("FAIL one_size: got %0d writes want one of 25", sz_q.size()); else n_pass++;
    n_chk++; if (obs_q.size() != 25 || obs_q[0] !== 1'b1 || par !== 24'h864CFB)
      $display("FAIL one_parity: got %h (len %0d) want 864cfb (len 25)", par, obs_q.size()); else n_pass++;
    n_chk++; if (frame_diff() != 0) $display("FAIL one_frame: diff %0d want 0", frame_diff()); else n_pass++;
  endtask

  task automatic test_gaps();
    logic b[$];
    clear();
    for (int i = 0; i < 8; i++) b.push_back(1'b0);
    model(b);
    send_size(8);
    send_bits(b, 50, -1, 0);
    wait_frame(32, -1, 0);
    n_chk++; if (frame_diff() != 0) $display("FAIL gaps_frame: diff %0d want 0", frame_diff()); else n_pass++;
    n_chk++; if (hs_cyc.size() != 8 || latency_err(8, 0) != 0)
      $display("FAIL gaps_latency: %0d late outputs of %0d handshakes, want 0 of 8", latency_err(8, 0), hs_cyc.size()); else n_pass++;
  endtask

  task automatic test_size_err();
    clear();
    err_pulses = 0;
    send_size(65512);
    repeat (5) @(negedge clk);
    #1;
    n_chk++; if (err_pulses != 1) $display("FAIL err_pulse: got %0d pulses want 1", err_pulses); else n_pass++;
    n_chk++; if (sz_q.size() != 0 || obs_q.size() != 0)
      $display("FAIL err_no_write: got %0d size / %0d data writes want 0", sz_q.size(), obs_q.size()); else n_pass++;
    n_chk++; if (size_ready !== 1'b1 || busy !== 1'b0) $display("FAIL err_idle: size_ready %b busy %b want 1 0", size_ready, busy); else n_pass++;
    send_size(65511);
    repeat (3) @(negedge clk);
    n_chk++; if (sz_q.size() != 1 || sz_q[0] !== 16'hFFFF)
      $display("FAIL err_max_size: got %0d writes, first %0d, want 65535", sz_q.size(), sz_q.size() ? sz_q[0] : 0); else n_pass++;
    n_chk++; if (err_pulses != 1) $display("FAIL err_max_no_pulse: got %0d pulses want 1", err_pulses); else n_pass++;
    do_reset();
  endtask

  task automatic test_hold();
    logic b[$];
    logic ref_q[$];
    rand_bits(16, b);
    clear();
    send_size(16);
    send_bits(b, 20, -1, 0);
    wait_frame(40, -1, 0);
    ref_q = obs_q;
    model(b);
    n_chk++; if (frame_diff() != 0) $display("FAIL hold_ref_frame: diff %0d want 0", frame_diff()); else n_pass++;
    clear();
    hold_viol = 0;
    send_size(16);
    send_bits(b, 0, 8, 5);
    wait_frame(40, 26, 5);
    n_chk++; if (obs_q != ref_q) $display("FAIL hold_same_seq: lengths %0d vs %0d or bits differ", obs_q.size(), ref_q.size()); else n_pass++;
    n_chk++; if (hold_viol != 0) $display("FAIL hold_quiet: got %0d activity cycles under hold want 0", hold_viol); else n_pass++;
    n_chk++; if (latency_err(16, 0) != 0) $display("FAIL hold_latency: got %0d late want 0", latency_err(16, 0)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic b[$];
    rand_bits(3, b);
    clear();
    send_size(10);
    send_bits(b, 0, -1, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    n_chk++; if (busy !== 1'b0 || size_ready !== 1'b1 || data_ready !== 1'b0)
      $display("FAIL rmid_idle: busy %b size_ready %b data_ready %b want 0 1 0", busy, size_ready, data_ready); else n_pass++;
    n_chk++; if (wreq_data !== 1'b0 || wreq_size !== 1'b0)
      $display("FAIL rmid_strobes: wreq_data %b wreq_size %b want 0 0", wreq_data, wreq_size); else n_pass++;
    reset = 1'b0;
    clear();
    repeat (30) @(negedge clk);
    n_chk++; if (obs_q.size() != 0 || sz_q.size() != 0)
      $display("FAIL rmid_abandon: got %0d data / %0d size writes want 0", obs_q.size(), sz_q.size()); else n_pass++;
    rand_bits(1, b);
    model(b);
    send_size(1);
    send_bits(b, 0, -1, 0);
    wait_frame(25, -1, 0);
    n_chk++; if (sz_q.size() != 1 || sz_q[0] !== 16'd25) $display("FAIL rmid_size: got %0d writes want one of 25", sz_q.size()); else n_pass++;
    n_chk++; if (frame_diff() != 0) $display("FAIL rmid_frame: diff %0d want 0", frame_diff()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic b1[$], b2[$];
    int a1, a2;
    for (int r = 0; r < 3; r++) begin
      a1 = $urandom_range(64, 1);
      a2 = $urandom_range(64, 1);
      rand_bits(a1, b1);
      rand_bits(a2, b2);
      clear();
      model(b1);
      model(b2);
      send_size(a1);
      send_bits(b1, $urandom_range(60), -1, 0);
      send_size(a2);
      send_bits(b2, $urandom_range(60), -1, 0);
      wait_frame(a1 + a2 + 48, -1, 0);
      n_chk++; if (sz_q.size() != 2 || sz_q[0] !== 16'(a1 + 24) || sz_q[1] !== 16'(a2 + 24))
        $display("FAIL b2b_sizes: got %0d writes want %0d,%0d", sz_q.size(), a1 + 24, a2 + 24); else n_pass++;
      n_chk++; if (frame_diff() != 0) $display("FAIL b2b_frames: diff %0d want 0 (A=%0d,%0d)", frame_diff(), a1, a2); else n_pass++;
      n_chk++; if (sz_cyc.size() != 2 || obs_cyc.size() != a1 + a2 + 48 ||
                   sz_cyc[1] - obs_cyc[a1+23] < 2 || sz_cyc[1] >= obs_cyc[a1+24])
        $display("FAIL b2b_gap: second size write not separated from first frame's last parity bit"); else n_pass++;
      n_chk++; if (hs_cyc.size() != a1 + a2 || latency_err(a1, 24) != 0)
        $display("FAIL b2b_latency: %0d late of %0d handshakes want 0", latency_err(a1, 24), hs_cyc.size()); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_one_bit();
    test_gaps();
    test_size_err();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
